// File: rtl/spi_slave_rx.sv
// SPI slave: deserialises MOSI into words and serialises tx_data onto MISO, all CPOL/CPHA modes.
// Latency: data_recv/rx_valid/word_cnt update on the sample edge of the last bit of each word.
// No backpressure: the master owns sclk; csn high discards any partial word.
module spi_slave_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL       = 1,
  parameter int CPHA       = 1
) (
  input  logic                  sclk,
  input  logic                  arstn,
  input  logic                  csn,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] data_recv,
  output logic                  rx_valid,
  output logic [7:0]            word_cnt
);

  localparam int             IW         = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0]  LAST       = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0]  ONE        = IW'(1);
  localparam bit             SAMPLE_NEG = ((CPOL ^ CPHA) != 0);

  logic                  samp_clk;
  logic                  shift_clk;
  logic [IW-1:0]         rx_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [IW-1:0]         tx_idx;
  logic                  tx_first;
  logic                  last_bit;

  // Sample and shift edges are opposite polarities of sclk; the mode picks which is which.
  assign samp_clk  = SAMPLE_NEG ? ~sclk : sclk;
  assign shift_clk = ~samp_clk;
  assign last_bit  = (rx_cnt == LAST);

  // Receive frame state: bit counter and shift register, cleared by reset or deselect.
  always_ff @(posedge samp_clk or posedge arstn or posedge csn) begin
    if (arstn) begin
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else if (csn) begin
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else begin
      rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi};
      rx_cnt   <= last_bit ? '0 : rx_cnt + ONE;
    end
  end

  // Word results survive deselect; only reset clears them. rx_valid drops at the first bit of a new word.
  always_ff @(posedge samp_clk or posedge arstn) begin
    if (arstn) begin
      data_recv <= '0;
      rx_valid  <= 1'b0;
      word_cnt  <= '0;
    end else if (!csn) begin
      if (last_bit) begin
        data_recv <= {rx_shift[DATA_WIDTH-2:0], mosi};
        rx_valid  <= 1'b1;
        word_cnt  <= word_cnt + 8'd1;
      end else if (rx_cnt == '0) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit bit index; with CPHA=1 the first shift edge launches bit 0 rather than advancing.
  always_ff @(posedge shift_clk or posedge arstn or posedge csn) begin
    if (arstn) begin
      tx_idx   <= '0;
      tx_first <= 1'b1;
    end else if (csn) begin
      tx_idx   <= '0;
      tx_first <= 1'b1;
    end else if ((CPHA != 0) && tx_first) begin
      tx_first <= 1'b0;
    end else begin
      tx_idx <= (tx_idx == LAST) ? '0 : tx_idx + ONE;
    end
  end

  // MISO is driven straight from tx_data so CPHA=0 has the MSB out as soon as csn falls.
  assign miso = (arstn || csn) ? 1'b0 : tx_data[LAST - tx_idx];

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side SPI slave for the serial-protocol block set; it is the far-end peer of `spi_master`. It deserialises MOSI into parallel words and serialises a parallel transmit word onto MISO, running entirely in the `sclk` domain. It supports all four CPOL/CPHA modes and back-to-back words within one `csn` assertion. It also keeps a running count of completed words for the consuming logic.

## Interface
- DATA_WIDTH, 8, word length in bits, ≥2
- CPOL, 1, sclk idle level: 0 idles low, 1 idles high
- CPHA, 1, phase selector. CPOL^CPHA==0: sample on posedge sclk, shift on negedge. CPOL^CPHA==1: sample on negedge, shift on posedge.
- Reset and clock: reset arstn, asynchronous, active-high; clock sclk.
- sclk  in  1  SPI serial clock from master; the only clock
- arstn  in  1  asynchronous reset, active-high (1 = reset)
- csn  in  1  chip select, active-low; high asynchronously clears frame state
- mosi  in  1  serial data from master, MSB first
- miso  out  1  serial data to master, MSB first
- tx_data  in  DATA_WIDTH  word to transmit; must be stable from csn fall to csn rise
- data_recv  out  DATA_WIDTH  last completely received word
- rx_valid  out  1  data_recv holds a new word from the current or most recent frame
- word_cnt  out  8  completed-word counter, wraps 255→0

## Operation
- Frame state consists of rx_cnt (bit index, 0..DATA_WIDTH-1), rx_shift, tx_idx (0..DATA_WIDTH-1) and tx_first (CPHA=1 only).
  - arstn=1 clears it asynchronously to rx_cnt=0, tx_idx=0, tx_first=1.
  - csn=1 clears the same frame state, also asynchronously.
- Sample edge, with csn=0:
  - rx_shift <= {rx_shift[W-2:0], mosi}.
  - If rx_cnt==W-1: data_recv <= {rx_shift[W-2:0], mosi}, rx_valid <= 1, word_cnt <= word_cnt+1, rx_cnt <= 0.
  - Else: rx_cnt <= rx_cnt+1. If rx_cnt==0, rx_valid <= 0.
- Shift edge, with csn=0:
  - CPHA=0: tx_idx <= (tx_idx==W-1) ? 0 : tx_idx+1.
  - CPHA=1: if tx_first, tx_first <= 0 and tx_idx is held at 0 (this edge launches bit 0). Otherwise tx_idx advances with wrap, as for CPHA=0.
- miso is combinational: csn=1 or arstn=1 → 0; otherwise → tx_data[W-1-tx_idx].
  - CPHA=0: the MSB is on miso as soon as csn falls.
- Burst: if csn stays low past W bits, both counters wrap and the next word is received. tx_data is retransmitted unless the source changes it; a changed tx_data takes effect at bit 0 of the next word.
- Aborted frame (csn rises mid-word): the partial word is discarded. data_recv, rx_valid and word_cnt are unchanged, and the next frame starts at bit 0.
- Unaffected by csn: data_recv, rx_valid and word_cnt. Only arstn clears them.

## Timing
- Reset values: data_recv=0, rx_valid=0, word_cnt=0, miso=0.
- Receive latency: data_recv, rx_valid and word_cnt update on the sample edge of the last bit (edge W of the word). No further sclk edge is required.
- rx_valid stays high while sclk is stopped. It drops on the first sample edge of the next word.
- Consumers in the sclk domain sample data_recv after the last-bit sample edge. Crossing to another clock domain is handled by a separate synchroniser block, not by this block.
- miso timing:
  - CPHA=0: bit k is valid from shift edge k (or from csn fall for k=0) until shift edge k+1.
  - CPHA=1: bit k is valid from shift edge k+1 until shift edge k+2.
- Simultaneous events:
  - arstn has priority over everything.
  - csn=1 has priority over sclk edges for frame state.
  - A sample edge that coincides with csn rising is ignored.

## Test plan
- Reset then idle: arstn=1 with csn=1 and sclk toggling → data_recv=0x00, rx_valid=0, word_cnt=0, miso=0; no state change.
- Mode 3 (CPOL=1, CPHA=1), master sends 0xA5 with tx_data=0x3C → data_recv=0xA5, rx_valid=1, word_cnt=1; master receives 0x3C MSB first.
- Second frame of 0x9A → rx_valid=0 after the first sample edge, then data_recv=0x9A, rx_valid=1, word_cnt=2.
- Modes 0/1/2 with 0xA5 in, tx_data=0xC3 → correct capture and correct MISO bit order in every mode. CPHA=0: miso=1 immediately after csn falls.
- Burst: csn low for 16 bits carrying 0x12, 0x34 → data_recv=0x12 after bit 8 and 0x34 after bit 16; word_cnt +2; miso repeats tx_data.
- Abort and wrap:
  - csn raised after 3 bits → data_recv and word_cnt unchanged; the next full frame of 0x5A is captured correctly.
  - 256 words → word_cnt wraps to 0.
  - arstn pulsed mid-word → all outputs return to reset values.
